pipe_hazard_unit: RTL and testbench
===================================

// Module: pipe_hazard_unit
// PURPOSE
// - Consumer of the 5-bit destination-register numbers held in the pipeline registers:
//   tracks in-flight writers through E, M and W and decides stall/forward for the instruction in D.
// - Sits beside the D stage of the 4-stage pipeline (D, E, M, W).
// - Drives the PC/IR write-enables (inverted Stall) and the operand forwarding muxes.
// PARAMETERS
// - REG_W   5    register-number width (32 registers; register 0 is hard-wired zero)
// - CNT_W   16   width of the stall performance counter
// PORTS
// - Clk        in   1      clock, rising edge
// - Clr        in   1      asynchronous reset, active-high
// - Issue      in   1      D holds a valid instruction
// - Flush      in   1      kill the D instruction (taken branch); it enters E as a bubble
// - Rs         in   REG_W  D source A number
// - Rt         in   REG_W  D source B number
// - Use_rs     in   1      D reads Rs
// - Use_rt     in   1      D reads Rt
// - Rd         in   REG_W  D destination number
// - Wreg       in   1      D writes Rd
// - Mem2reg    in   1      D is a load (result available at end of M)
// - Stall      out  1      hold D and PC this cycle; E receives a bubble
// - FwdA       out  2      source A select: 00 regfile, 01 E ALU, 10 M ALU, 11 M mem data
// - FwdB       out  2      source B select, same encoding
// - Stall_cnt  out  CNT_W  cycles with Stall=1 since reset, saturating
// BEHAVIOUR
// - State: three stage slots E, M and W. Each slot holds {v, rd, ld} in flops with an async clear.
// - Clr=1 clears every v, rd, ld and Stall_cnt at once, including mid-operation.
//   Outputs then read: Stall=0, FwdA=FwdB=00, Stall_cnt=0.
// - Every rising edge:
//   - W <= M.
//   - M <= E.
//   - E <= {Issue & Wreg & ~Stall & ~Flush & (Rd!=0), Rd, Mem2reg}.
//     - If v=0, rd and ld are forced to 0 (a bubble).
// - Match rule: matchX(s) = Use_s & (s!=0) & X.v & (X.rd==s), for X in {E, M}.
//   - W never matches: the regfile writes on the falling edge, so D reads the new value.
// - Stall, FwdA, FwdB and Stall_cnt are combinational from state and the D inputs.
//   - Zero-cycle decision for the current D instruction.
//   - Stall is forced to 0 when Issue=0 or Flush=1 (Flush wins over Stall).
// - Stall_cnt increments on each edge where Stall=1 and holds at all-ones (no wrap).
// - Priority: a match in E beats a match in M (newest value wins). Rs and Rt are evaluated independently.
// - Boundaries:
//   - Rs=Rt: both selects are identical.
//   - Rd=0 writers never enter as valid.
//   - Stall on consecutive cycles repeats until the blocking writer leaves the relevant slot.
//   - With Issue=0, FwdA=FwdB=00.
// CONFIGURATION
// - Macro PIPE_HAZARD_FWD_EN.
// - Defined:
//   - Stall = matchE(Rs|Rt) & E.ld (load-use only).
//   - Otherwise Fwd = 01 on an E match, 11 on an M match with M.ld=1, 10 on an M match with M.ld=0.
//   - Maximum one stall cycle per load-use.
// - Undefined:
//   - Stall on any E or M match.
//   - FwdA=FwdB=00 always.
//   - The ld bit is still tracked, for uniform state.
// TESTING
// - Reset: Clr pulse mid-stream with E.v=1 -> Stall=0, Fwd=00, Stall_cnt=0 immediately, before the next edge.
// - ALU chain: issue add r3; next cycle issue Rs=3.
//   - FWD_EN: Stall=0, FwdA=01.
//   - No FWD_EN: Stall for 2 cycles, then FwdA=00.
// - Load-use: issue lw r5; next cycle Rt=5.
//   - FWD_EN: Stall=1 for 1 cycle, then FwdB=11.
//   - No FWD_EN: 2 stall cycles.
//   - Stall_cnt increments by the stall count.
// - Priority: add r4 then sub r4, then Rs=4 (FWD_EN) -> FwdA=01 (E), not 10.
// - Register 0 and Flush: writer Rd=0 then Rs=0 -> no Stall, Fwd=00.
//   - Flush=1 on a load -> E.v=0, and a following Rs match does not stall.
// - Saturation: force a permanent Stall for 2^CNT_W+3 cycles -> Stall_cnt=all-ones, no wrap.

Source files
------------

// File: rtl/pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_unit
// Purpose  : Hazard detection for a 4-stage (D, E, M, W) pipeline. It tracks
//            the destination register of every in-flight writer in the E, M
//            and W stage slots. For the instruction sitting in D it decides,
//            in the same cycle, whether that instruction must stall and where
//            each source operand must come from.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   Clk        in   1      clock, rising edge
//   Clr        in   1      asynchronous reset, active-high
//   Issue      in   1      D holds a valid instruction
//   Flush      in   1      kill the D instruction; it enters E as a bubble
//   Rs / Rt    in   REG_W  D source A / source B register numbers
//   Use_rs/rt  in   1      D actually reads Rs / Rt
//   Rd         in   REG_W  D destination register number
//   Wreg       in   1      D writes Rd
//   Mem2reg    in   1      D is a load (data only available at end of M)
//   Stall      out  1      hold PC and D this cycle; E receives a bubble
//   FwdA/FwdB  out  2      00 regfile, 01 E ALU, 10 M ALU, 11 M mem data
//   Stall_cnt  out  CNT_W  saturating count of stalled cycles since reset
// Parameters
//   REG_W  register-number width (register 0 is hard-wired zero)
//   CNT_W  width of the stall performance counter
// Configuration
//   PIPE_HAZARD_FWD_EN  defined   : forwarding paths present, only load-use
//                                   hazards stall (one cycle each).
//                       undefined : no forwarding, any pending writer of a
//                                   source in E or M stalls D; FwdA/FwdB = 00.
// ============================================================================
module pipe_hazard_unit #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             Issue,
    input  logic             Flush,
    input  logic [REG_W-1:0] Rs,
    input  logic [REG_W-1:0] Rt,
    input  logic             Use_rs,
    input  logic             Use_rt,
    input  logic [REG_W-1:0] Rd,
    input  logic             Wreg,
    input  logic             Mem2reg,
    output logic             Stall,
    output logic [1:0]       FwdA,
    output logic [1:0]       FwdB,
    output logic [CNT_W-1:0] Stall_cnt
);

    // ------------------------------------------------------------------------
    // Operand source encodings
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_FWD_RF    = 2'b00;
`ifdef PIPE_HAZARD_FWD_EN
    localparam logic [1:0] c_FWD_E_ALU = 2'b01;
    localparam logic [1:0] c_FWD_M_ALU = 2'b10;
    localparam logic [1:0] c_FWD_M_MEM = 2'b11;
`endif

    // ------------------------------------------------------------------------
    // Stage slots: {valid, destination register, is-load}
    // ------------------------------------------------------------------------
    logic             r_e_v;
    logic [REG_W-1:0] r_e_rd;
    logic             r_e_ld;
    logic             r_m_v;
    logic [REG_W-1:0] r_m_rd;
    logic             r_m_ld;
    logic             r_w_v;
    logic [REG_W-1:0] r_w_rd;
    logic             r_w_ld;

    logic [CNT_W-1:0] r_stall_cnt;

    // ------------------------------------------------------------------------
    // Source matching against in-flight writers. W is never consulted: the
    // register file writes on the falling edge, so D already reads the value.
    // ------------------------------------------------------------------------
    logic w_rs_live;
    logic w_rt_live;
    logic w_match_e_a;
    logic w_match_e_b;
    logic w_match_m_a;
    logic w_match_m_b;
    logic w_hazard;
    logic w_stall;
    logic w_e_v_next;

    always_comb begin
        w_rs_live   = Use_rs & (Rs != '0);
        w_rt_live   = Use_rt & (Rt != '0);
        w_match_e_a = w_rs_live & r_e_v & (r_e_rd == Rs);
        w_match_e_b = w_rt_live & r_e_v & (r_e_rd == Rt);
        w_match_m_a = w_rs_live & r_m_v & (r_m_rd == Rs);
        w_match_m_b = w_rt_live & r_m_v & (r_m_rd == Rt);
    end

`ifdef PIPE_HAZARD_FWD_EN
    // Newest producer wins: an E match overrides an M match. A load in M
    // supplies its memory data, an ALU result in M its ALU output.
    function automatic logic [1:0] f_fwd_sel(
        input logic match_e,
        input logic match_m,
        input logic m_is_load
    );
        logic [1:0] sel;
        sel = c_FWD_RF;
        if (match_e) begin
            sel = c_FWD_E_ALU;
        end else if (match_m) begin
            sel = m_is_load ? c_FWD_M_MEM : c_FWD_M_ALU;
        end
        return sel;
    endfunction

    // Only a load still in E cannot be forwarded in time; one bubble moves it
    // to M, where its memory data is reachable.
    assign w_hazard = (w_match_e_a | w_match_e_b) & r_e_ld;

    // The W slot is carried for uniform state but has no consumer here.
    logic w_unused_state;
    assign w_unused_state = ^{r_w_v, r_w_rd, r_w_ld};
`else
    // Without forwarding every pending writer of a source blocks D until it
    // reaches W.
    assign w_hazard = w_match_e_a | w_match_e_b | w_match_m_a | w_match_m_b;

    // The ld bits and W slot are still tracked so the state looks the same in
    // both builds; nothing reads them in this one.
    logic w_unused_state;
    assign w_unused_state = ^{r_w_v, r_w_rd, r_w_ld, r_e_ld, r_m_ld};
`endif

    // A killed or absent D instruction never stalls.
    assign w_stall = Issue & ~Flush & w_hazard;

    // Only real writers of a non-zero register enter E as valid; everything
    // else (stall bubble, flush, idle, r0 write) becomes an all-zero bubble.
    assign w_e_v_next = Issue & Wreg & ~w_stall & ~Flush & (Rd != '0);

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign Stall     = w_stall;
    assign Stall_cnt = r_stall_cnt;

`ifdef PIPE_HAZARD_FWD_EN
    always_comb begin
        FwdA = c_FWD_RF;
        FwdB = c_FWD_RF;
        if (Issue && !w_stall) begin
            FwdA = f_fwd_sel(w_match_e_a, w_match_m_a, r_m_ld);
            FwdB = f_fwd_sel(w_match_e_b, w_match_m_b, r_m_ld);
        end
    end
`else
    assign FwdA = c_FWD_RF;
    assign FwdB = c_FWD_RF;
`endif

    // ------------------------------------------------------------------------
    // Stage slot advance
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            r_e_v  <= 1'b0;
            r_e_rd <= '0;
            r_e_ld <= 1'b0;
            r_m_v  <= 1'b0;
            r_m_rd <= '0;
            r_m_ld <= 1'b0;
            r_w_v  <= 1'b0;
            r_w_rd <= '0;
            r_w_ld <= 1'b0;
        end else begin
            r_w_v  <= r_m_v;
            r_w_rd <= r_m_rd;
            r_w_ld <= r_m_ld;
            r_m_v  <= r_e_v;
            r_m_rd <= r_e_rd;
            r_m_ld <= r_e_ld;
            r_e_v  <= w_e_v_next;
            r_e_rd <= w_e_v_next ? Rd : '0;
            r_e_ld <= w_e_v_next & Mem2reg;
        end
    end

    // ------------------------------------------------------------------------
    // Stall performance counter, saturating at all-ones
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_unit
// Purpose  : Directed self-checking bench for pipe_hazard_unit. Expected
//            values are hand-derived for both PIPE_HAZARD_FWD_EN builds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_unit;

    localparam int REG_W = 5;
    localparam int CNT_W = 8;

    logic             Clk;
    logic             Clr;
    logic             Issue;
    logic             Flush;
    logic [REG_W-1:0] Rs;
    logic [REG_W-1:0] Rt;
    logic             Use_rs;
    logic             Use_rt;
    logic [REG_W-1:0] Rd;
    logic             Wreg;
    logic             Mem2reg;
    logic             Stall;
    logic [1:0]       FwdA;
    logic [1:0]       FwdB;
    logic [CNT_W-1:0] Stall_cnt;

    int n_vec;
    int n_err;

    pipe_hazard_unit #(
        .REG_W (REG_W),
        .CNT_W (CNT_W)
    ) dut (
        .Clk       (Clk),
        .Clr       (Clr),
        .Issue     (Issue),
        .Flush     (Flush),
        .Rs        (Rs),
        .Rt        (Rt),
        .Use_rs    (Use_rs),
        .Use_rt    (Use_rt),
        .Rd        (Rd),
        .Wreg      (Wreg),
        .Mem2reg   (Mem2reg),
        .Stall     (Stall),
        .FwdA      (FwdA),
        .FwdB      (FwdB),
        .Stall_cnt (Stall_cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic iss, input logic fl,
                         input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                         input logic urs, input logic urt,
                         input logic [REG_W-1:0] rd, input logic wr, input logic ld);
        Issue   = iss;
        Flush   = fl;
        Rs      = rs;
        Rt      = rt;
        Use_rs  = urs;
        Use_rt  = urt;
        Rd      = rd;
        Wreg    = wr;
        Mem2reg = ld;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drain();
        idle();
        tick();
        tick();
        tick();
    endtask

    initial begin
        int k;
        n_vec = 0;
        n_err = 0;

        // Reset state
        Clr = 1'b1;
        idle();
        #2;
        chk("rst_stall", Stall, 0);
        chk("rst_fwda", FwdA, 0);
        chk("rst_fwdb", FwdB, 0);
        chk("rst_cnt", Stall_cnt, 0);
        tick();
        Clr = 1'b0;

        // ALU chain: add r3, then a reader of r3
        drive(1, 0, 1, 2, 1, 1, 3, 1, 0);
        #2 chk("alu_issue_stall", Stall, 0);
        tick();
        drive(1, 0, 3, 0, 1, 0, 6, 1, 0);
        #2;
`ifdef PIPE_HAZARD_FWD_EN
        chk("alu_stall", Stall, 0);
        chk("alu_fwda_e", FwdA, 1);
        chk("alu_fwdb", FwdB, 0);
        tick();
`else
        chk("alu_stall1", Stall, 1);
        tick();
        #2 chk("alu_stall2", Stall, 1);
        tick();
        #2;
        chk("alu_stall3", Stall, 0);
        chk("alu_fwda_rf", FwdA, 0);
        tick();
`endif
        drain();
`ifdef PIPE_HAZARD_FWD_EN
        chk("alu_cnt", Stall_cnt, 0);
`else
        chk("alu_cnt", Stall_cnt, 2);
`endif

        // Load-use: lw r5, then a reader of r5 on Rt
        drive(1, 0, 0, 0, 0, 0, 5, 1, 1);
        #2 chk("lu_issue_stall", Stall, 0);
        tick();
        drive(1, 0, 0, 5, 0, 1, 0, 0, 0);
        #2 chk("lu_stall1", Stall, 1);
        tick();
`ifdef PIPE_HAZARD_FWD_EN
        #2;
        chk("lu_stall2", Stall, 0);
        chk("lu_fwdb_mem", FwdB, 3);
        chk("lu_fwda", FwdA, 0);
        tick();
`else
        #2 chk("lu_stall2", Stall, 1);
        tick();
        #2;
        chk("lu_stall3", Stall, 0);
        chk("lu_fwdb_rf", FwdB, 0);
        tick();
`endif
        drain();
`ifdef PIPE_HAZARD_FWD_EN
        chk("lu_cnt", Stall_cnt, 1);
`else
        chk("lu_cnt", Stall_cnt, 4);
`endif

        // Priority: add r4, sub r4, then Rs=Rt=4
        drive(1, 0, 0, 0, 0, 0, 4, 1, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 4, 1, 0);
        tick();
        drive(1, 0, 4, 4, 1, 1, 0, 0, 0);
        #2;
`ifdef PIPE_HAZARD_FWD_EN
        chk("prio_stall", Stall, 0);
        chk("prio_fwda_e", FwdA, 1);
        chk("prio_fwdb_e", FwdB, 1);
        tick();
        // sub r4 now in M with E empty: M ALU path
        drive(1, 0, 4, 0, 1, 0, 0, 0, 0);
        #2;
        chk("m_alu_stall", Stall, 0);
        chk("m_alu_fwda", FwdA, 2);
        tick();
`else
        chk("prio_stall1", Stall, 1);
        tick();
        #2 chk("prio_stall2", Stall, 1);
        tick();
        #2;
        chk("prio_stall3", Stall, 0);
        chk("prio_fwda", FwdA, 0);
        chk("prio_fwdb", FwdB, 0);
        tick();
`endif
        drain();

        // Register 0 writer never becomes valid
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        drive(1, 0, 0, 0, 1, 1, 0, 0, 0);
        #2;
        chk("r0_stall", Stall, 0);
        chk("r0_fwda", FwdA, 0);
        chk("r0_fwdb", FwdB, 0);
        tick();
        drain();

        // Flushed load enters E as a bubble
        drive(1, 1, 0, 0, 0, 0, 7, 1, 1);
        #2 chk("flush_ld_stall", Stall, 0);
        tick();
        drive(1, 0, 7, 0, 1, 0, 0, 0, 0);
        #2;
        chk("after_flush_stall", Stall, 0);
        chk("after_flush_fwda", FwdA, 0);
        tick();
        drain();

        // Flush beats a pending load-use stall
        drive(1, 0, 0, 0, 0, 0, 8, 1, 1);
        tick();
        drive(1, 1, 8, 0, 1, 0, 0, 0, 0);
        #2 chk("flush_wins", Stall, 0);
        tick();
        drive(1, 0, 8, 0, 1, 0, 0, 0, 0);
        #2;
`ifdef PIPE_HAZARD_FWD_EN
        chk("flush_next_stall", Stall, 0);
        chk("flush_next_fwda", FwdA, 3);
`else
        chk("flush_next_stall", Stall, 1);
`endif
        tick();
        drain();

        // Issue=0 suppresses stall and forwarding
        drive(1, 0, 0, 0, 0, 0, 10, 1, 1);
        tick();
        drive(0, 0, 10, 10, 1, 1, 0, 0, 0);
        #2;
        chk("noiss_stall", Stall, 0);
        chk("noiss_fwda", FwdA, 0);
        chk("noiss_fwdb", FwdB, 0);
        tick();
        drain();
`ifdef PIPE_HAZARD_FWD_EN
        chk("pre_sat_cnt", Stall_cnt, 1);
`else
        chk("pre_sat_cnt", Stall_cnt, 7);
`endif

        // Saturation: repeated load-use stalls well past 2^CNT_W+3 stall cycles
        for (int it = 0; it < 300; it++) begin
            drive(1, 0, 0, 0, 0, 0, 1, 1, 1);
            tick();
            k = 0;
            while (k < 4) begin
                drive(1, 0, 1, 0, 1, 0, 0, 0, 0);
                #2;
                if (!Stall) break;
                tick();
                k++;
            end
            if (k == 4) begin
                n_vec++;
                n_err++;
                $error("FAIL sat_bound: observed stall persisting expected release");
            end
            tick();
            if (it == 9) begin
`ifdef PIPE_HAZARD_FWD_EN
                chk("sat_mid_cnt", Stall_cnt, 11);
`else
                chk("sat_mid_cnt", Stall_cnt, 27);
`endif
            end
        end
        drain();
        chk("sat_cnt", Stall_cnt, 255);

        // Mid-stream asynchronous clear with E.v=1 and an active stall
        drive(1, 0, 0, 0, 0, 0, 9, 1, 1);
        tick();
        drive(1, 0, 0, 9, 0, 1, 0, 0, 0);
        #2 chk("pre_clr_stall", Stall, 1);
        #1 Clr = 1'b1;
        #1;
        chk("clr_stall", Stall, 0);
        chk("clr_fwda", FwdA, 0);
        chk("clr_fwdb", FwdB, 0);
        chk("clr_cnt", Stall_cnt, 0);
        tick();
        Clr = 1'b0;
        #2 chk("post_clr_stall", Stall, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
